// File: rtl/int_div_iterative_pkg.sv
// Shared definitions for the iterative divider: function codes, FSM states
// and the iteration counter width.
package int_div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } func_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must reach p_nbits-1; keep at least one bit for tiny widths.
  function automatic int cnt_width(input int nbits);
    return (nbits <= 2) ? 1 : $clog2(nbits);
  endfunction

endpackage

// File: rtl/int_div_iterative_if.sv
// Request/response val/rdy bundle between a requester (master) and the
// divider (slave).
interface int_div_iterative_if #(
  parameter int p_nbits = 32
);

  logic               req_val;
  logic               req_rdy;
  logic [1:0]         req_func;
  logic [p_nbits-1:0] req_a;
  logic [p_nbits-1:0] req_b;
  logic               resp_val;
  logic               resp_rdy;
  logic [p_nbits-1:0] resp_result;

  modport master (
    output req_val, req_func, req_a, req_b, resp_rdy,
    input  req_rdy, resp_val, resp_result
  );

  modport slave (
    input  req_val, req_func, req_a, req_b, resp_rdy,
    output req_rdy, resp_val, resp_result
  );

endinterface

// File: rtl/int_div_iterative_dpath.sv
// Divider datapath: operand magnitudes, restoring subtract/shift step,
// iteration counter and the final sign fix-up into the result register.
module int_div_iterative_dpath
  import int_div_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               fixup,
  input  logic [1:0]         func,
  input  logic [p_nbits-1:0] a,
  input  logic [p_nbits-1:0] b,
  output logic               count_done,
  output logic               b_zero,
  output logic [p_nbits-1:0] result
);

  localparam int CW = cnt_width(p_nbits);
  localparam logic [CW-1:0] LAST_CNT = CW'(p_nbits - 1);

  logic [p_nbits-1:0] r;
  logic [p_nbits-1:0] q;
  logic [p_nbits-1:0] d;
  logic [CW-1:0]      cnt;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero_r;
  logic [1:0]         func_r;

  logic               signed_op;
  logic               in_sign_a;
  logic               in_sign_b;
  logic [p_nbits-1:0] mag_a;
  logic [p_nbits-1:0] mag_b;
  logic [p_nbits:0]   diff;
  logic [p_nbits-1:0] next_r;
  logic [p_nbits-1:0] next_q;
  logic [p_nbits-1:0] quot;
  logic [p_nbits-1:0] rem;

  always_comb begin
    signed_op = (func == DIV) || (func == REM);
    in_sign_a = signed_op & a[p_nbits-1];
    in_sign_b = signed_op & b[p_nbits-1];
    mag_a     = in_sign_a ? -a : a;
    mag_b     = in_sign_b ? -b : b;
  end

  // The shifted partial remainder keeps R's top bit, so the trial subtract is
  // p_nbits+1 wide and stays correct for unsigned divisors above 2^(n-1).
  always_comb begin
    diff = {r, q[p_nbits-1]} - {1'b0, d};
    if (!diff[p_nbits]) begin
      next_r = diff[p_nbits-1:0];
      next_q = {q[p_nbits-2:0], 1'b1};
    end else begin
      next_r = {r[p_nbits-2:0], q[p_nbits-1]};
      next_q = {q[p_nbits-2:0], 1'b0};
    end
    quot = ((sign_a ^ sign_b) && !b_zero_r) ? -next_q : next_q;
    rem  = sign_a ? -next_r : next_r;
  end

  // Fix-up happens on the same edge as the final step, so it consumes next_q/next_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      r        <= '0;
      q        <= '0;
      d        <= '0;
      cnt      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      b_zero_r <= 1'b0;
      func_r   <= 2'd0;
      result   <= '0;
    end else begin
      if (load) begin
        r        <= '0;
        q        <= mag_a;
        d        <= mag_b;
        cnt      <= '0;
        sign_a   <= in_sign_a;
        sign_b   <= in_sign_b;
        b_zero_r <= (b == '0);
        func_r   <= func;
      end else if (step) begin
        r   <= next_r;
        q   <= next_q;
        cnt <= cnt + 1'b1;
      end
      if (fixup) begin
        result <= ((func_r == DIV) || (func_r == DIVU)) ? quot : rem;
      end
    end
  end

  assign count_done = (cnt == LAST_CNT);
  assign b_zero     = b_zero_r;

endmodule

// File: rtl/int_div_iterative.sv
// Iterative radix-2 restoring DIV/DIVU/REM/REMU unit: control FSM and
// val/rdy handshaking around the divider datapath.
module int_div_iterative
  import int_div_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  int_div_iterative_if.slave   io
);

  state_t state;
  logic   req_rdy_r;
  logic   resp_val_r;
  logic   load;
  logic   step;
  logic   fixup;
  logic   count_done;
  logic   b_zero;

  assign load  = (state == IDLE) && io.req_val && req_rdy_r;
  assign step  = (state == CALC);
  assign fixup = step && count_done;

  // Handshake outputs are registered alongside the state so they change only on edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_rdy_r  <= 1'b1;
      resp_val_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state     <= CALC;
            req_rdy_r <= 1'b0;
          end
        end
        CALC: begin
          if (count_done) begin
            state      <= DONE;
            resp_val_r <= 1'b1;
          end
        end
        DONE: begin
          if (io.resp_rdy) begin
            state      <= IDLE;
            resp_val_r <= 1'b0;
            req_rdy_r  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          req_rdy_r  <= 1'b1;
          resp_val_r <= 1'b0;
        end
      endcase
    end
  end

  assign io.req_rdy  = req_rdy_r;
  assign io.resp_val = resp_val_r;

  int_div_iterative_dpath #(
    .p_nbits (p_nbits)
  ) dpath (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .fixup      (fixup),
    .func       (io.req_func),
    .a          (io.req_a),
    .b          (io.req_b),
    .count_done (count_done),
    .b_zero     (b_zero),
    .result     (io.resp_result)
  );

  // b_zero is folded into the fix-up inside the datapath; the FSM needs no special case.
  logic unused_ok;
  assign unused_ok = b_zero;

endmodule
